// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: access encodings, FSM states, lane widths.
package cpu_pkg;

  localparam int BE_W = 4;

  typedef enum logic [3:0] {
    MEM_B  = 4'b0000,
    MEM_H  = 4'b0001,
    MEM_W  = 4'b0010,
    MEM_BU = 4'b0100,
    MEM_HU = 4'b0101
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Unlisted encodings fall through to a full-word access.
  function automatic acc_size_e op_size(input logic [3:0] op);
    case (op)
      MEM_B, MEM_BU: return SZ_B;
      MEM_H, MEM_HU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic op_unsigned(input logic [3:0] op);
    return (op == MEM_BU) || (op == MEM_HU);
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction with sign/zero extension.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offs,
  input  acc_size_e             size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offs, 3'b000} +: 8];
    half_sel = rdata[{offs[1], 4'b0000} +: 16];
    data     = rdata;
    case (size)
      SZ_B: begin
        if (is_unsigned) data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
        else             data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        if (is_unsigned) data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        else             data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: data-bus handshake with timeout, lane steering, MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN adds a misaligned-access trap and port MEM_misalign_o.
//
// state   | meaning
// ST_IDLE | no access outstanding; a new access requests the bus combinationally
// ST_WAIT | request held (upstream frozen) until ack or timeout
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           MEM_pc_i,
  input  logic [31:0]           MEM_pc_dest_i,
  input  logic [4:0]            MEM_rd_add_i,
  input  logic [1:0]            MEM_sel_to_reg_i,
  input  logic                  MEM_regwrite_i,
  input  logic                  MEM_RD_mem_i,
  input  logic                  MEM_WR_mem_i,
  input  logic [3:0]            MEM_mem_op_i,
  input  logic [31:0]           MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_rs2_data_i,
  input  logic                  MEM_zero_i,
  input  logic                  MEM_branch_i,
  input  logic                  MEM_jump_i,
  input  logic                  dmem_ack_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [31:0]           dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [BE_W-1:0]       dmem_be_o,
  output logic                  MEM_stall_o,
  output logic                  MEM_pc_src_o,
  output logic                  MEM_flush_o,
  output logic                  MEM_bus_err_o,
  output logic [31:0]           MEM_pc_o,
  output logic [31:0]           MEM_alu_result_o,
  output logic [DATA_WIDTH-1:0] MEM_rdata_o,
  output logic [4:0]            MEM_rd_add_o,
  output logic [1:0]            MEM_sel_to_reg_o,
  output logic                  MEM_regwrite_o
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic                MEM_misalign_o
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  mem_state_e            state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  active;
  logic                  timeout;
  logic                  misalign;
  logic                  take_branch;
  logic [1:0]            offs;
  acc_size_e             size;
  logic                  is_unsigned;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  unused_pc_dest;

  // The redirect target is consumed by the fetch stage; this stage only decides when.
  assign unused_pc_dest = ^MEM_pc_dest_i;

  assign active      = MEM_RD_mem_i | MEM_WR_mem_i;
  assign offs        = MEM_alu_result_i[1:0];
  assign size        = op_size(MEM_mem_op_i);
  assign is_unsigned = op_unsigned(MEM_mem_op_i);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = active && (state == ST_IDLE) &&
                    (((size == SZ_H) && offs[0]) || ((size == SZ_W) && (offs != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // An ack landing on the last allowed cycle wins over the timeout.
  assign timeout = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !dmem_ack_i;

  assign MEM_stall_o = active && !misalign && !dmem_ack_i && !timeout;

  assign dmem_req_o = ((state == ST_IDLE) && active && !misalign) ||
                      ((state == ST_WAIT) && !timeout);
  assign dmem_we_o   = MEM_WR_mem_i && !MEM_RD_mem_i;
  assign dmem_addr_o = {MEM_alu_result_i[31:2], 2'b00};

  always_comb begin
    dmem_be_o    = '1;
    dmem_wdata_o = MEM_rs2_data_i;
    case (size)
      SZ_B: begin
        dmem_be_o    = 4'b0001 << offs;
        dmem_wdata_o = {(DATA_WIDTH/8){MEM_rs2_data_i[7:0]}};
      end
      SZ_H: begin
        dmem_be_o    = 4'b0011 << {offs[1], 1'b0};
        dmem_wdata_o = {(DATA_WIDTH/16){MEM_rs2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign take_branch  = MEM_jump_i || (MEM_branch_i && MEM_zero_i);
  assign MEM_pc_src_o = take_branch && !MEM_stall_o;
  assign MEM_flush_o  = take_branch && !MEM_stall_o;

  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .rdata       (dmem_rdata_i),
    .offs        (offs),
    .size        (size),
    .is_unsigned (is_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      MEM_bus_err_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      MEM_misalign_o <= 1'b0;
`endif
    end else begin
      MEM_bus_err_o <= timeout;
`ifdef MEM_MISALIGN_TRAP_EN
      MEM_misalign_o <= misalign;
`endif
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (active && !misalign && !dmem_ack_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dmem_ack_i || timeout) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubbles while stalled, on timeout, or on a trapped access.
  always_ff @(posedge clk) begin
    if (rst || MEM_stall_o || timeout || misalign) begin
      MEM_pc_o         <= '0;
      MEM_alu_result_o <= '0;
      MEM_rdata_o      <= '0;
      MEM_rd_add_o     <= '0;
      MEM_sel_to_reg_o <= '0;
      MEM_regwrite_o   <= 1'b0;
    end else begin
      MEM_pc_o         <= MEM_pc_i;
      MEM_alu_result_o <= MEM_alu_result_i;
      MEM_rdata_o      <= load_data;
      MEM_rd_add_o     <= MEM_rd_add_i;
      MEM_sel_to_reg_o <= MEM_sel_to_reg_i;
      MEM_regwrite_o   <= MEM_regwrite_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: aligned/sub-word loads and stores, wait states, timeout, branch, reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_pc_i, MEM_pc_dest_i, MEM_alu_result_i, MEM_rs2_data_i, dmem_rdata_i;
  logic [4:0]  MEM_rd_add_i;
  logic [1:0]  MEM_sel_to_reg_i;
  logic        MEM_regwrite_i, MEM_RD_mem_i, MEM_WR_mem_i, MEM_zero_i, MEM_branch_i, MEM_jump_i;
  logic [3:0]  MEM_mem_op_i;
  logic        dmem_ack_i;
  logic        dmem_req_o, dmem_we_o, MEM_stall_o, MEM_pc_src_o, MEM_flush_o, MEM_bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, MEM_pc_o, MEM_alu_result_o, MEM_rdata_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  MEM_rd_add_o;
  logic [1:0]  MEM_sel_to_reg_o;
  logic        MEM_regwrite_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MEM_misalign_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_stage #(.DATA_WIDTH(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .MEM_pc_i(MEM_pc_i), .MEM_pc_dest_i(MEM_pc_dest_i), .MEM_rd_add_i(MEM_rd_add_i),
    .MEM_sel_to_reg_i(MEM_sel_to_reg_i), .MEM_regwrite_i(MEM_regwrite_i),
    .MEM_RD_mem_i(MEM_RD_mem_i), .MEM_WR_mem_i(MEM_WR_mem_i), .MEM_mem_op_i(MEM_mem_op_i),
    .MEM_alu_result_i(MEM_alu_result_i), .MEM_rs2_data_i(MEM_rs2_data_i),
    .MEM_zero_i(MEM_zero_i), .MEM_branch_i(MEM_branch_i), .MEM_jump_i(MEM_jump_i),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .MEM_stall_o(MEM_stall_o), .MEM_pc_src_o(MEM_pc_src_o), .MEM_flush_o(MEM_flush_o),
    .MEM_bus_err_o(MEM_bus_err_o), .MEM_pc_o(MEM_pc_o), .MEM_alu_result_o(MEM_alu_result_o),
    .MEM_rdata_o(MEM_rdata_o), .MEM_rd_add_o(MEM_rd_add_o),
    .MEM_sel_to_reg_o(MEM_sel_to_reg_o), .MEM_regwrite_o(MEM_regwrite_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .MEM_misalign_o(MEM_misalign_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MEM_pc_i = '0; MEM_pc_dest_i = '0; MEM_rd_add_i = '0; MEM_sel_to_reg_i = '0;
    MEM_regwrite_i = 1'b0; MEM_RD_mem_i = 1'b0; MEM_WR_mem_i = 1'b0; MEM_mem_op_i = 4'b0010;
    MEM_alu_result_i = '0; MEM_rs2_data_i = '0; MEM_zero_i = 1'b0; MEM_branch_i = 1'b0;
    MEM_jump_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [3:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rdat, input logic [4:0] rdest);
    idle_inputs();
    MEM_RD_mem_i = rd; MEM_WR_mem_i = wr; MEM_mem_op_i = op;
    MEM_alu_result_i = addr; MEM_rs2_data_i = wd; dmem_ack_i = ack; dmem_rdata_i = rdat;
    MEM_rd_add_i = rdest; MEM_regwrite_i = rd; MEM_sel_to_reg_i = 2'd1; MEM_pc_i = 32'h40;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk("rst_regwrite", {31'd0, MEM_regwrite_o}, 32'd0);
    chk("rst_rdata", MEM_rdata_o, 32'd0);
    chk("rst_pc", MEM_pc_o, 32'd0);
    chk("rst_bus_err", {31'd0, MEM_bus_err_o}, 32'd0);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    rst = 1'b0;

    // LW, zero-wait ack
    drive(1'b1, 1'b0, 4'b0010, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 5'd5);
    chk("lw_req", {31'd0, dmem_req_o}, 32'd1);
    chk("lw_stall", {31'd0, MEM_stall_o}, 32'd0);
    chk("lw_be", {28'd0, dmem_be_o}, 32'hF);
    chk("lw_addr", dmem_addr_o, 32'h100);
    chk("lw_we", {31'd0, dmem_we_o}, 32'd0);
    tick();
    chk("lw_rdata", MEM_rdata_o, 32'hDEADBEEF);
    chk("lw_regwrite", {31'd0, MEM_regwrite_o}, 32'd1);
    chk("lw_rd_add", {27'd0, MEM_rd_add_o}, 32'd5);
    chk("lw_pc", MEM_pc_o, 32'h40);

    // Sub-word loads
    drive(1'b1, 1'b0, 4'b0000, 32'h103, 32'h0, 1'b1, 32'h80112233, 5'd6);
    chk("lb_be", {28'd0, dmem_be_o}, 32'b1000);
    tick();
    chk("lb_rdata", MEM_rdata_o, 32'hFFFFFF80);
    drive(1'b1, 1'b0, 4'b0100, 32'h103, 32'h0, 1'b1, 32'h80112233, 5'd6);
    tick();
    chk("lbu_rdata", MEM_rdata_o, 32'h00000080);
    drive(1'b1, 1'b0, 4'b0001, 32'h102, 32'h0, 1'b1, 32'h80112233, 5'd6);
    chk("lh_be", {28'd0, dmem_be_o}, 32'b1100);
    tick();
    chk("lh_rdata", MEM_rdata_o, 32'hFFFF8011);
    drive(1'b1, 1'b0, 4'b0101, 32'h100, 32'h0, 1'b1, 32'h80112233, 5'd6);
    tick();
    chk("lhu_rdata", MEM_rdata_o, 32'h00002233);

    // Stores
    drive(1'b0, 1'b1, 4'b0001, 32'h202, 32'h0000ABCD, 1'b1, 32'h0, 5'd0);
    chk("sh_be", {28'd0, dmem_be_o}, 32'b1100);
    chk("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
    chk("sh_we", {31'd0, dmem_we_o}, 32'd1);
    chk("sh_addr", dmem_addr_o, 32'h200);
    drive(1'b0, 1'b1, 4'b0000, 32'h201, 32'h12345677, 1'b1, 32'h0, 5'd0);
    chk("sb_be", {28'd0, dmem_be_o}, 32'b0010);
    chk("sb_wdata", dmem_wdata_o, 32'h77777777);
`ifndef MEM_MISALIGN_TRAP_EN
    drive(1'b0, 1'b1, 4'b1111, 32'h203, 32'hA5A51234, 1'b1, 32'h0, 5'd0);
    chk("odd_op_be", {28'd0, dmem_be_o}, 32'hF);
    chk("odd_op_wdata", dmem_wdata_o, 32'hA5A51234);
    chk("odd_op_addr", dmem_addr_o, 32'h200);
`endif
    drive(1'b1, 1'b1, 4'b0010, 32'h300, 32'h1, 1'b1, 32'h0, 5'd1);
    chk("rdwr_prio_we", {31'd0, dmem_we_o}, 32'd0);
    tick();

    // Load acked after three wait cycles, branch suppressed while stalled
    drive(1'b1, 1'b0, 4'b0010, 32'h300, 32'h0, 1'b0, 32'h0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin MEM_branch_i = 1'b1; MEM_zero_i = 1'b1; #1; end
      chk("wait_stall", {31'd0, MEM_stall_o}, 32'd1);
      chk("wait_req", {31'd0, dmem_req_o}, 32'd1);
      if (i == 1) chk("wait_pc_src", {31'd0, MEM_pc_src_o}, 32'd0);
      tick();
      chk("wait_bubble", {31'd0, MEM_regwrite_o}, 32'd0);
    end
    MEM_branch_i = 1'b0; MEM_zero_i = 1'b0;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D; #1;
    chk("ack3_stall", {31'd0, MEM_stall_o}, 32'd0);
    tick();
    chk("ack3_rdata", MEM_rdata_o, 32'hCAFEF00D);
    chk("ack3_regwrite", {31'd0, MEM_regwrite_o}, 32'd1);
    chk("ack3_rd_add", {27'd0, MEM_rd_add_o}, 32'd7);

    // Timeout: stall for 16 cycles, then req drops and bus_err pulses
    drive(1'b1, 1'b0, 4'b0010, 32'h400, 32'h0, 1'b0, 32'h0, 5'd9);
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!MEM_stall_o) break;
      stall_cnt++;
      tick();
    end
    chk("to_stall_cycles", stall_cnt, 32'd16);
    chk("to_req_drop", {31'd0, dmem_req_o}, 32'd0);
    tick();
    chk("to_bus_err", {31'd0, MEM_bus_err_o}, 32'd1);
    chk("to_bubble", {31'd0, MEM_regwrite_o}, 32'd0);
    idle_inputs();
    tick();
    chk("to_bus_err_pulse", {31'd0, MEM_bus_err_o}, 32'd0);

    // Ack on the timeout cycle completes normally
    drive(1'b1, 1'b0, 4'b0010, 32'h500, 32'h0, 1'b0, 32'h0, 5'd10);
    for (int i = 0; i < 16; i++) tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h13572468; #1;
    chk("late_ack_stall", {31'd0, MEM_stall_o}, 32'd0);
    chk("late_ack_req", {31'd0, dmem_req_o}, 32'd1);
    tick();
    chk("late_ack_err", {31'd0, MEM_bus_err_o}, 32'd0);
    chk("late_ack_rdata", MEM_rdata_o, 32'h13572468);
    chk("late_ack_regwrite", {31'd0, MEM_regwrite_o}, 32'd1);

    // Branch/jump redirect with no access
    idle_inputs(); MEM_branch_i = 1'b1; MEM_zero_i = 1'b1; #1;
    chk("br_pc_src", {31'd0, MEM_pc_src_o}, 32'd1);
    chk("br_flush", {31'd0, MEM_flush_o}, 32'd1);
    MEM_zero_i = 1'b0; #1;
    chk("br_not_taken", {31'd0, MEM_pc_src_o}, 32'd0);
    MEM_jump_i = 1'b1; #1;
    chk("jump_flush", {31'd0, MEM_flush_o}, 32'd1);

    // ALU pass-through
    idle_inputs(); MEM_regwrite_i = 1'b1; MEM_rd_add_i = 5'd3; MEM_alu_result_i = 32'h55;
    MEM_sel_to_reg_i = 2'd2; MEM_pc_i = 32'h80; #1;
    tick();
    chk("alu_result", MEM_alu_result_o, 32'h55);
    chk("alu_sel", {30'd0, MEM_sel_to_reg_o}, 32'd2);

    // Reset in the middle of a wait
    drive(1'b1, 1'b0, 4'b0010, 32'h600, 32'h0, 1'b0, 32'h0, 5'd11);
    tick(); tick();
    chk("pre_rst_req", {31'd0, dmem_req_o}, 32'd1);
    rst = 1'b1; idle_inputs();
    tick();
    chk("mid_rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("mid_rst_regwrite", {31'd0, MEM_regwrite_o}, 32'd0);
    chk("mid_rst_pc", MEM_pc_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_stall", {31'd0, MEM_stall_o}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 4'b0010, 32'h101, 32'h0, 1'b0, 32'h0, 5'd12);
    chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
    chk("mis_stall", {31'd0, MEM_stall_o}, 32'd0);
    tick();
    chk("mis_pulse", {31'd0, MEM_misalign_o}, 32'd1);
    chk("mis_regwrite", {31'd0, MEM_regwrite_o}, 32'd0);
    idle_inputs();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, maximum cycles in WAIT before bus error.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports (name direction width meaning):
- clk in 1: clock
- rst in 1: synchronous active-high reset
- MEM_pc_i in 32: EX/MEM PC
- MEM_pc_dest_i in 32: branch/jump target
- MEM_rd_add_i in 5: destination register
- MEM_sel_to_reg_i in 2: writeback select
- MEM_regwrite_i in 1: register write enable
- MEM_RD_mem_i in 1: load
- MEM_WR_mem_i in 1: store
- MEM_mem_op_i in 4: access size/sign
- MEM_alu_result_i in 32: address or ALU result
- MEM_rs2_data_i in 32: store data
- MEM_zero_i in 1: ALU zero
- MEM_branch_i in 1: branch
- MEM_jump_i in 1: jump
- dmem_ack_i in 1: memory acknowledge
- dmem_rdata_i in 32: read data
- dmem_req_o out 1: memory request
- dmem_we_o out 1: write
- dmem_addr_o out 32: word address (bits [1:0] zero)
- dmem_wdata_o out 32: lane-aligned write data
- dmem_be_o out 4: byte enables
- MEM_stall_o out 1: freeze upstream stages
- MEM_pc_src_o out 1: redirect PC to MEM_pc_dest_i
- MEM_flush_o out 1: flush IF/ID/EX
- MEM_bus_err_o out 1: one-cycle timeout pulse
- MEM_pc_o, MEM_alu_result_o, MEM_rdata_o out 32: MEM/WB register
- MEM_rd_add_o out 5; MEM_sel_to_reg_o out 2; MEM_regwrite_o out 1: MEM/WB register

Function
REQ-005 mem_op encodings SHALL be: B=0000, H=0001, W=0010, BU=0100, HU=0101; any other value SHALL be treated as W.
REQ-006 An access SHALL be active when MEM_RD_mem_i or MEM_WR_mem_i is 1, with load taking priority if both are set.
REQ-007 FSM states SHALL be IDLE and WAIT: IDLE->WAIT on active access without dmem_ack_i; WAIT->IDLE on dmem_ack_i or timeout.
REQ-008 dmem_req_o SHALL be asserted combinationally in IDLE for an active access and held in WAIT; address/data/be/we SHALL be stable, because upstream is frozen.
REQ-009 Byte enables: B/BU = 0001<<addr[1:0]; H/HU = 0011<<{addr[1],0}; W = 1111. Write data SHALL be replicated into all byte/half lanes.
REQ-010 Load data SHALL be lane-extracted using addr[1:0], sign-extended for B/H, and zero-extended for BU/HU.
REQ-011 MEM_stall_o SHALL equal (active access AND NOT dmem_ack_i AND NOT timeout); zero-wait ack SHALL give zero stall.
REQ-012 A wait counter SHALL clear in IDLE and increment each WAIT cycle; at count TIMEOUT_CYC-1 the block SHALL drop req, pulse MEM_bus_err_o, and return to IDLE.
REQ-013 MEM/WB register SHALL capture inputs and extracted rdata on every non-stall cycle (latency 1); during stall or on timeout it SHALL load a bubble (regwrite=0, rd=0).
REQ-014 MEM_pc_src_o and MEM_flush_o SHALL equal MEM_jump_i OR (MEM_branch_i AND MEM_zero_i), combinationally; they SHALL be forced to 0 while MEM_stall_o=1.
REQ-015 An ack arriving in the same cycle as timeout SHALL complete normally, with no error.

Reset
REQ-016 On rst=1 at a clock edge: FSM=IDLE, counter=0, all MEM/WB outputs=0, MEM_bus_err_o=0; reset mid-WAIT SHALL abandon the access, with dmem_req_o=0 the following cycle.

Configuration
REQ-017 With MEM_MISALIGN_TRAP_EN defined: misaligned H/HU (addr[0]) or W (addr[1:0]!=0) SHALL suppress dmem_req_o, load a bubble, and pulse MEM_misalign_o (extra out 1). Without the macro, the port is absent and low address bits outside the access size SHALL be ignored.

Structure
REQ-018 mem_op encodings, FSM state enum and byte-enable width SHALL live in shared package cpu_pkg.
REQ-019 Load extraction/extension SHALL be sub-module load_align (combinational); the FSM and registers stay in mem_stage.

Verification
REQ-020 LW with addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall; next cycle MEM_rdata_o=0xDEADBEEF, regwrite_o=1.
REQ-021 LB with addr 0x103, rdata 0x80112233 -> MEM_rdata_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-022 SH with addr 0x202, rs2 0x0000ABCD -> dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1.
REQ-023 Load with ack after 3 cycles -> MEM_stall_o high 3 cycles, WB bubbles, then correct data; no ack for 16 cycles -> MEM_bus_err_o pulse and req drop.
REQ-024 branch=1, zero=1, no access -> pc_src_o=flush_o=1 same cycle; rst asserted mid-WAIT -> req=0 and outputs zero next cycle.
REQ-025 With MEM_MISALIGN_TRAP_EN defined, LW at 0x101 -> no request, MEM_misalign_o pulse, regwrite_o=0.
